// File: rtl/sq_wave_gen_ctrl_pkg.sv
// Shared defaults and types for the square-wave sample generator.
// Used by the generator and by the square-wave top that instantiates it.
package sq_wave_gen_ctrl_pkg;

   localparam int DEF_CODE_WIDTH      = 10;
   localparam int DEF_MID_CODE        = 512;
   localparam int DEF_AMPLITUDE       = 50;
   localparam int DEF_HALF_PERIOD_INIT = 139;
   localparam int DEF_HALF_PERIOD_MIN = 16;
   localparam int DEF_HALF_PERIOD_MAX = 4095;
   localparam int DEF_STEP            = 10;

   typedef enum logic {
      PH_LOW  = 1'b0,
      PH_HIGH = 1'b1
   } phase_t;

   typedef enum logic [1:0] {
      PCMD_HOLD = 2'd0,
      PCMD_UP   = 2'd1,
      PCMD_DOWN = 2'd2
   } pcmd_t;

   // Simultaneous up and down pulses cancel out.
   function automatic pcmd_t decode_pcmd(input logic up, input logic down);
      pcmd_t cmd;
      cmd = PCMD_HOLD;
      if (up && !down) begin
         cmd = PCMD_UP;
      end else if (down && !up) begin
         cmd = PCMD_DOWN;
      end
      return cmd;
   endfunction

endpackage

// File: rtl/sq_wave_gen_ctrl_period_ctrl.sv
// Half-period register with saturating linear (+/-STEP) or exponential (x2, /2) steps.
// All step arithmetic is one bit wider than the register so nothing wraps.
module sq_wave_period_ctrl
   import sq_wave_gen_ctrl_pkg::*;
#(
   parameter int PERIOD_WIDTH = 12,
   parameter int HP_INIT      = DEF_HALF_PERIOD_INIT,
   parameter int HP_MIN       = DEF_HALF_PERIOD_MIN,
   parameter int HP_MAX       = DEF_HALF_PERIOD_MAX,
   parameter int STEP         = DEF_STEP
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    freq_up,
   input  logic                    freq_down,
   input  logic                    exp_mode,
   output logic [PERIOD_WIDTH-1:0] half_period
);

   localparam int EW = PERIOD_WIDTH + 1;

   localparam logic [EW-1:0] MIN_EXT  = EW'(HP_MIN);
   localparam logic [EW-1:0] MAX_EXT  = EW'(HP_MAX);
   localparam logic [EW-1:0] STEP_EXT = EW'(STEP);

   logic [EW-1:0] hp_ext;
   logic [EW-1:0] up_raw;
   logic [EW-1:0] up_val;
   logic [EW-1:0] down_raw;
   logic [EW-1:0] down_val;
   pcmd_t         cmd;

   assign hp_ext = {1'b0, half_period};
   assign cmd    = decode_pcmd(freq_up, freq_down);

   always_comb begin
      up_raw = hp_ext >> 1;
      if (!exp_mode) begin
         // Checked before subtracting so a small half period cannot wrap.
         up_raw = (hp_ext < STEP_EXT) ? '0 : hp_ext - STEP_EXT;
      end
      up_val = (up_raw < MIN_EXT) ? MIN_EXT : up_raw;
   end

   always_comb begin
      down_raw = exp_mode ? (hp_ext << 1) : (hp_ext + STEP_EXT);
      down_val = (down_raw > MAX_EXT) ? MAX_EXT : down_raw;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         half_period <= PERIOD_WIDTH'(HP_INIT);
      end else begin
         case (cmd)
            PCMD_UP:   half_period <= up_val[PERIOD_WIDTH-1:0];
            PCMD_DOWN: half_period <= down_val[PERIOD_WIDTH-1:0];
            default:   half_period <= half_period;
         endcase
      end
   end

endmodule

// File: rtl/sq_wave_gen_ctrl.sv
// Square-wave DAC sample generator: one code per next_sample strobe, level toggles
// every half_period samples, with runtime frequency control and mute.
//
//   state   | meaning
//   PH_LOW  | emitting MID_CODE-AMPLITUDE (also the restart state after mute/reset)
//   PH_HIGH | emitting MID_CODE+AMPLITUDE
module sq_wave_gen_ctrl
   import sq_wave_gen_ctrl_pkg::*;
#(
   parameter int CODE_WIDTH       = DEF_CODE_WIDTH,
   parameter int MID_CODE         = DEF_MID_CODE,
   parameter int AMPLITUDE        = DEF_AMPLITUDE,
   parameter int HALF_PERIOD_INIT = DEF_HALF_PERIOD_INIT,
   parameter int HALF_PERIOD_MIN  = DEF_HALF_PERIOD_MIN,
   parameter int HALF_PERIOD_MAX  = DEF_HALF_PERIOD_MAX,
   parameter int STEP             = DEF_STEP,
   parameter int PERIOD_WIDTH     = $clog2(HALF_PERIOD_MAX + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    next_sample,
   input  logic                    enable,
   input  logic                    freq_up,
   input  logic                    freq_down,
   input  logic                    exp_mode,
   output logic [CODE_WIDTH-1:0]   code,
   output logic [PERIOD_WIDTH-1:0] half_period
);

   localparam logic [CODE_WIDTH-1:0] CODE_MID  = CODE_WIDTH'(MID_CODE);
   localparam logic [CODE_WIDTH-1:0] CODE_HIGH = CODE_WIDTH'(MID_CODE + AMPLITUDE);
   localparam logic [CODE_WIDTH-1:0] CODE_LOW  = CODE_WIDTH'(MID_CODE - AMPLITUDE);

   if (MID_CODE < AMPLITUDE) begin : g_bad_amplitude
      $error("sq_wave_gen_ctrl: MID_CODE must be >= AMPLITUDE");
   end
   if (MID_CODE + AMPLITUDE >= (1 << CODE_WIDTH)) begin : g_bad_code_width
      $error("sq_wave_gen_ctrl: MID_CODE+AMPLITUDE does not fit in CODE_WIDTH");
   end
   if (HALF_PERIOD_MIN < 1 || HALF_PERIOD_MIN > HALF_PERIOD_INIT ||
       HALF_PERIOD_INIT > HALF_PERIOD_MAX) begin : g_bad_period_bounds
      $error("sq_wave_gen_ctrl: need 1 <= MIN <= INIT <= MAX half period");
   end

   logic [PERIOD_WIDTH-1:0] count;
   logic [PERIOD_WIDTH-1:0] count_nx;
   phase_t                  phase;
   phase_t                  phase_nx;
   logic                    terminal;

   sq_wave_period_ctrl #(
      .PERIOD_WIDTH (PERIOD_WIDTH),
      .HP_INIT      (HALF_PERIOD_INIT),
      .HP_MIN       (HALF_PERIOD_MIN),
      .HP_MAX       (HALF_PERIOD_MAX),
      .STEP         (STEP)
   ) u_period_ctrl (
      .clk         (clk),
      .rst         (rst),
      .freq_up     (freq_up),
      .freq_down   (freq_down),
      .exp_mode    (exp_mode),
      .half_period (half_period)
   );

   // count >= hp-1, written as count+1 >= hp; >= lets a shrunken period end at once.
   assign terminal = ({1'b0, count} + (PERIOD_WIDTH + 1)'(1)) >= {1'b0, half_period};

   always_comb begin
      count_nx = count;
      phase_nx = phase;
      if (!enable) begin
         count_nx = '0;
         phase_nx = PH_LOW;
      end else if (next_sample) begin
         if (terminal) begin
            count_nx = '0;
            phase_nx = (phase == PH_HIGH) ? PH_LOW : PH_HIGH;
         end else begin
            count_nx = count + PERIOD_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         phase <= PH_LOW;
         code  <= CODE_LOW;
      end else begin
         count <= count_nx;
         phase <= phase_nx;
         if (!enable) begin
            code <= CODE_MID;
         end else begin
            code <= (phase_nx == PH_HIGH) ? CODE_HIGH : CODE_LOW;
         end
      end
   end

endmodule

// File: tb/tb_sq_wave_gen_ctrl.sv
// Directed bench for sq_wave_gen_ctrl with default parameters.
module tb_sq_wave_gen_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        next_sample = 1'b0;
   logic        enable = 1'b1;
   logic        freq_up = 1'b0;
   logic        freq_down = 1'b0;
   logic        exp_mode = 1'b0;
   logic [9:0]  code;
   logic [11:0] half_period;

   int errors = 0;
   int checks = 0;

   sq_wave_gen_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .next_sample (next_sample),
      .enable      (enable),
      .freq_up     (freq_up),
      .freq_down   (freq_down),
      .exp_mode    (exp_mode),
      .code        (code),
      .half_period (half_period)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   int exp_hp_seq[6] = '{278, 556, 1112, 2224, 4095, 4095};

   initial begin
      // reset state
      tick(2);
      chk("reset_code", 32'(code), 462);
      chk("reset_hp", 32'(half_period), 139);

      // free-running wave, one strobe per cycle
      rst = 1'b0;
      next_sample = 1'b1;
      tick(138);
      chk("low_last", 32'(code), 462);
      tick(1);
      chk("first_high", 32'(code), 562);
      tick(138);
      chk("high_last", 32'(code), 562);
      tick(1);
      chk("second_low", 32'(code), 462);

      // shrink period mid half: count=100, hp 139 -> 69
      tick(100);
      chk("mid_low_code", 32'(code), 462);
      next_sample = 1'b0;
      exp_mode = 1'b1;
      freq_up = 1'b1;
      tick(1);
      freq_up = 1'b0;
      chk("hp_halved", 32'(half_period), 69);
      chk("hold_no_strobe", 32'(code), 462);
      next_sample = 1'b1;
      tick(1);
      chk("shrink_toggle", 32'(code), 562);
      tick(68);
      chk("new_half_last", 32'(code), 562);
      tick(1);
      chk("new_half_end", 32'(code), 462);

      // mute in the middle of a high half, then restart
      tick(69);
      tick(10);
      chk("mid_high", 32'(code), 562);
      enable = 1'b0;
      tick(1);
      chk("mute_code", 32'(code), 512);
      tick(3);
      chk("mute_hold", 32'(code), 512);
      enable = 1'b1;
      next_sample = 1'b0;
      tick(1);
      chk("restart_low", 32'(code), 462);
      next_sample = 1'b1;
      tick(68);
      chk("restart_low_last", 32'(code), 462);
      tick(1);
      chk("restart_high", 32'(code), 562);

      // up and down together cancel; reset overrides a freq pulse
      next_sample = 1'b0;
      freq_up = 1'b1;
      freq_down = 1'b1;
      tick(1);
      freq_up = 1'b0;
      chk("both_pulses", 32'(half_period), 69);
      rst = 1'b1;
      tick(1);
      freq_down = 1'b0;
      chk("midwave_rst_hp", 32'(half_period), 139);
      chk("midwave_rst_code", 32'(code), 462);
      rst = 1'b0;

      // linear steps down to the lower bound
      exp_mode = 1'b0;
      freq_up = 1'b1;
      tick(1);
      chk("lin_up_1", 32'(half_period), 129);
      tick(11);
      chk("lin_up_12", 32'(half_period), 19);
      tick(1);
      chk("lin_up_sat", 32'(half_period), 16);
      tick(1);
      chk("lin_up_sat_hold", 32'(half_period), 16);
      freq_up = 1'b0;
      freq_down = 1'b1;
      tick(1);
      chk("lin_down", 32'(half_period), 26);
      freq_down = 1'b0;
      exp_mode = 1'b1;
      freq_up = 1'b1;
      tick(1);
      chk("exp_up_sat", 32'(half_period), 16);
      freq_up = 1'b0;

      // exponential steps up to the upper bound
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      freq_down = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         chk($sformatf("exp_down_%0d", i), 32'(half_period), 32'(exp_hp_seq[i]));
      end
      exp_mode = 1'b0;
      tick(1);
      chk("lin_down_sat", 32'(half_period), 4095);
      freq_down = 1'b0;
      freq_up = 1'b1;
      tick(1);
      chk("lin_up_from_max", 32'(half_period), 4085);
      freq_up = 1'b0;
      tick(2);
      chk("hp_hold", 32'(half_period), 4085);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
